uart_phy: RTL and testbench



---
 rtl/uart_phy.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_phy.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_phy.sv
// uart_phy: 8N1 serial PHY for the UART-lite peripheral.
//   Transmit side serializes one byte per tx_valid/tx_ready handshake onto
//   uart_tx (start bit, d[0]..d[7] LSB first, stop bit). Receive side
//   synchronizes uart_rx, centre-samples 8N1 frames and hands bytes to a
//   one-entry holding register with a valid/ready handshake.
// Ports:
//   clka          system clock (posedge)
//   rst_n         asynchronous active-low reset
//   tx_data/tx_valid/tx_ready   byte-level transmit handshake
//   rx_data/rx_valid/rx_ready   byte-level receive handshake (holding reg)
//   uart_tx       serial out, idle high, straight from a flop
//   uart_rx       serial in, asynchronous to clka
//   rx_frame_err  one-cycle pulse: stop bit sampled low, byte dropped
//   rx_overrun    one-cycle pulse: byte dropped, holding register full
module uart_phy #(
  parameter int CLK_DIV   = 868,
  parameter int BIT_CNT_W = 16
) (
  input  logic       clka,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_phy: CLK_DIV must be in 4..65535");
  end
  if ((longint'(CLK_DIV) - 1) >= (longint'(1) << BIT_CNT_W)) begin : g_bad_cnt_w
    $error("uart_phy: BIT_CNT_W too narrow for CLK_DIV-1");
  end

  localparam logic [BIT_CNT_W-1:0] DIV_M1  = BIT_CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] DIV_HALF = BIT_CNT_W'(CLK_DIV / 2);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE = BIT_CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------------------------------------------------------- TX
  state_e               tx_state_q, tx_state_d;
  logic [BIT_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_expire;

  assign tx_expire = (tx_cnt_q == '0);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;   // line goes idle the moment reset asserts
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Every bit (start included) is counted DIV_M1..0, so each lasts exactly
  // CLK_DIV cycles; the next bit value is loaded into tx_q on expiry.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_state_d = S_START;
          tx_cnt_d   = DIV_M1;
          tx_shift_d = tx_data;
          tx_d       = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_expire) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_expire) begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_expire) begin
          tx_state_d = S_IDLE;
          tx_ready_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  assign uart_tx  = tx_q;
  assign tx_ready = tx_ready_q;

  // ---------------------------------------------------------------- RX
  // rx_s1/rx_s2 form the synchronizer; rx_s3 is the previous rx_s2 for
  // falling-edge detection. All reset high so reset never looks like a start.
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  state_e               rx_state_q, rx_state_d;
  logic [BIT_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_expire, rx_fall, rx_deliver, rx_load;

  assign rx_expire = (rx_cnt_q == '0);
  assign rx_fall   = rx_s3_q & ~rx_s2_q;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // Half a bit after the start edge lands mid-start-bit; every later sample
  // is a full CLK_DIV further, so samples stay at bit centres.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_deliver = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_d = S_START;
          rx_cnt_d   = DIV_HALF;
        end
      end
      S_START: begin
        if (rx_expire) begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;          // glitch, not a real start bit
          end else begin
            rx_state_d = S_DATA;
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_expire) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_expire) begin
          // Back to IDLE mid-stop-bit so the next start edge is not missed.
          rx_state_d = S_IDLE;
          if (rx_s2_q) rx_deliver = 1'b1;
          else         rx_ferr_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Holding register: a new byte may replace one being consumed this cycle.
  assign rx_load = rx_deliver && (!rx_valid_q || rx_ready);

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (rx_load) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_shift_q;
    end
    rx_ovr_d = rx_deliver && !rx_load;
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;

endmodule

// File: tb/tb_uart_phy.sv
// Directed bench for uart_phy at CLK_DIV=16: reset/idle, TX framing and
// back-to-back timing, loopback, overrun, simultaneous consume, glitch,
// frame error and mid-frame reset. Received bytes go through a scoreboard.
module tb_uart_phy;
  localparam int D = 16;

  logic       clka = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       uart_tx;
  logic       rx_pin;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_frame_err;
  logic       rx_overrun;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_got[$];

  assign rx_pin = loop_en ? uart_tx : rx_drv;

  uart_phy #(.CLK_DIV(D), .BIT_CNT_W(16)) dut (
    .clka(clka), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .uart_tx(uart_tx), .uart_rx(rx_pin),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  // Monitor on the falling edge, away from DUT updates and input changes.
  always @(negedge clka) begin
    if (rx_frame_err === 1'b1) err_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) rx_got.push_back(rx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clka); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_count"}, rx_got.size(), exp_q.size());
    while (rx_got.size() > 0 && exp_q.size() > 0)
      chk(tag, {24'd0, rx_got.pop_front()}, {24'd0, exp_q.pop_front()});
    rx_got.delete();
    exp_q.delete();
  endtask

  // Sends one byte and checks every cycle of the 10-bit frame.
  task automatic tx_frame(input logic [7:0] b, output int start_cyc);
    logic [9:0] frm;
    int bad, busy_bad;
    frm = {1'b1, b, 1'b0};
    chk("tx_ready_before", {31'd0, tx_ready}, 32'd1);
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    start_cyc = cyc;
    bad = 0; busy_bad = 0;
    for (int c = 0; c < 10 * D; c++) begin
      if (uart_tx !== frm[c / D]) bad++;
      if (tx_ready !== 1'b0) busy_bad++;
      tick();
    end
    chk("tx_bits", bad, 0);
    chk("tx_busy", busy_bad, 0);
    chk("tx_ready_after", {31'd0, tx_ready}, 32'd1);
  endtask

  // Drives one frame on the rx pin; optional one-cycle rx_ready pulse at pulse_c.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int pulse_c);
    logic [9:0] frm;
    frm = {stop, b, 1'b0};
    for (int c = 0; c < 10 * D; c++) begin
      rx_drv = frm[c / D];
      if (pulse_c >= 0) rx_ready = (c == pulse_c);
      tick();
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int s1, s2, e0, o0, bad;
    logic [7:0] lb [3];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;

    // Reset and idle
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clka);
    #1;
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (uart_tx !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) bad++;
      tick();
    end
    chk("idle_stable", bad, 0);
    chk("idle_ferr", err_cnt, 0);
    chk("idle_ovr", ovr_cnt, 0);

    // TX framing, back-to-back with no idle gap
    tx_frame(8'hA5, s1);
    tx_frame(8'h3C, s2);
    chk("tx_no_gap", s2 - s1, 10 * D + 1);

    // Loopback
    loop_en = 1'b1; rx_ready = 1'b1;
    e0 = err_cnt; o0 = ovr_cnt;
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(lb[i]);
      tx_frame(lb[i], s1);
    end
    repeat (20) tick();
    sb_check("loop");
    chk("loop_ferr", err_cnt - e0, 0);
    chk("loop_ovr", ovr_cnt - o0, 0);
    rx_ready = 1'b0; loop_en = 1'b0;
    tick();

    // Overrun: second byte dropped, first held
    e0 = err_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h12);
    rx_frame(8'h12, 1'b1, -1);
    rx_frame(8'h34, 1'b1, -1);
    repeat (4) tick();
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_data", {24'd0, rx_data}, 32'h12);
    chk("ovr_pulse", ovr_cnt - o0, 1);
    chk("ovr_ferr", err_cnt - e0, 0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("ovr_consumed", {31'd0, rx_valid}, 32'd0);
    chk("ovr_data_hold", {24'd0, rx_data}, 32'h12);
    sb_check("ovr");

    // Consume in the exact cycle the next byte completes
    o0 = ovr_cnt;
    exp_q.push_back(8'h56);
    rx_frame(8'h56, 1'b1, -1);
    repeat (2) tick();
    chk("sim_first", {24'd0, rx_data}, 32'h56);
    exp_q.push_back(8'h34);
    rx_frame(8'h34, 1'b1, 10 * D - 5);
    chk("sim_valid", {31'd0, rx_valid}, 32'd1);
    chk("sim_data", {24'd0, rx_data}, 32'h34);
    chk("sim_ovr", ovr_cnt - o0, 0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("sim_cleared", {31'd0, rx_valid}, 32'd0);
    sb_check("sim");

    // Short glitch
    e0 = err_cnt; o0 = ovr_cnt;
    rx_drv = 1'b0; repeat (3) tick(); rx_drv = 1'b1;
    repeat (40) tick();
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr", err_cnt - e0, 0);
    chk("glitch_ovr", ovr_cnt - o0, 0);

    // Frame error
    rx_frame(8'h99, 1'b0, -1);
    repeat (20) tick();
    chk("ferr_pulse", err_cnt - e0, 1);
    chk("ferr_valid", {31'd0, rx_valid}, 32'd0);
    chk("ferr_data", {24'd0, rx_data}, 32'h34);
    chk("ferr_ovr", ovr_cnt - o0, 0);
    sb_check("ferr");

    // Reset in the middle of a TX frame
    tx_data = 8'h00; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    repeat (20) tick();
    chk("midrst_pre", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", {31'd0, uart_tx}, 32'd1);
    chk("midrst_ready_async", {31'd0, tx_ready}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
    chk("midrst_tx", {31'd0, uart_tx}, 32'd1);
    tx_frame(8'hC3, s1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
